// File: rtl/tlu_event_framer.sv
// Pulls one 10-word TLU event from the 16-bit upstream port, then presents it as
// self-describing 32-bit words on a FWFT port. Optional ID tracking: TLU_FRAMER_ID_CHECK_EN.
module tlu_event_framer #(
    parameter logic [7:0] HEADER = 8'hC0
) (
    input  logic        BUS_CLK,
    input  logic        BUS_RST,
    input  logic        ENABLE,
    output logic        FIFO_READ,
    input  logic        FIFO_EMPTY,
    input  logic [15:0] FIFO_DATA,
    input  logic        OUT_FIFO_READ,
    output logic        OUT_FIFO_EMPTY,
    output logic [31:0] OUT_FIFO_DATA,
    output logic [31:0] EVENT_CNT,
    output logic [7:0]  ID_ERR_CNT,
    output logic        BUSY
);

    localparam int EVENT_WORDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  fill_idx_reg, fill_idx_next;
    logic [3:0]  out_idx_reg, out_idx_next;
    logic [15:0] buffer_reg [EVENT_WORDS];
    logic [31:0] word_fmt [EVENT_WORDS];
    logic [3:0]  flags_reg;
    logic        first_event_reg;
    logic [31:0] event_cnt_reg;
    logic        fifo_read_reg;
    logic        capture;
    logic        fill_last;
    logic        drain_last;
    logic        id_err;

    always_comb begin
        state_next    = state_reg;
        fill_idx_next = fill_idx_reg;
        out_idx_next  = out_idx_reg;
        capture       = 1'b0;
        fill_last     = 1'b0;
        drain_last    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ENABLE && !FIFO_EMPTY) begin
                    state_next    = FILL;
                    fill_idx_next = 4'd0;
                end
            end
            FILL: begin
                capture       = 1'b1;
                fill_idx_next = fill_idx_reg + 4'd1;
                if (fill_idx_reg == 4'(EVENT_WORDS - 1)) begin
                    fill_last    = 1'b1;
                    state_next   = DRAIN;
                    out_idx_next = 4'd0;
                end
            end
            DRAIN: begin
                // A pop is only possible here; reads while empty never reach this branch.
                if (OUT_FIFO_READ) begin
                    out_idx_next = out_idx_reg + 4'd1;
                    if (out_idx_reg == 4'(EVENT_WORDS - 1)) begin
                        drain_last = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_reg       <= IDLE;
            fill_idx_reg    <= 4'd0;
            out_idx_reg     <= 4'd0;
            fifo_read_reg   <= 1'b0;
            flags_reg       <= 4'd0;
            first_event_reg <= 1'b1;
            event_cnt_reg   <= 32'd0;
            for (int i = 0; i < EVENT_WORDS; i++) begin
                buffer_reg[i] <= 16'd0;
            end
        end else begin
            state_reg     <= state_next;
            fill_idx_reg  <= fill_idx_next;
            out_idx_reg   <= out_idx_next;
            // Registered pop strobe tracks the state register exactly, one flop later in logic.
            fifo_read_reg <= (state_next == FILL);
            if (capture) begin
                buffer_reg[fill_idx_reg] <= FIFO_DATA;
            end
            if (fill_last) begin
                flags_reg       <= {2'b00, first_event_reg, id_err};
                first_event_reg <= 1'b0;
            end
            if (drain_last) begin
                event_cnt_reg <= event_cnt_reg + 32'd1;
            end
        end
    end

`ifdef TLU_FRAMER_ID_CHECK_EN
    logic [31:0] assembled_id;
    logic [31:0] last_id_reg;
    logic [7:0]  id_err_cnt_reg;

    // The upper ID half is still on the bus during the final FILL cycle.
    assign assembled_id = {FIFO_DATA, buffer_reg[8]};
    assign id_err       = !first_event_reg && (assembled_id != last_id_reg + 32'd1);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            last_id_reg    <= 32'd0;
            id_err_cnt_reg <= 8'd0;
        end else if (fill_last) begin
            last_id_reg <= assembled_id;
            if (id_err && (id_err_cnt_reg != 8'hFF)) begin
                id_err_cnt_reg <= id_err_cnt_reg + 8'd1;
            end
        end
    end

    assign ID_ERR_CNT = id_err_cnt_reg;
`else
    assign id_err     = 1'b0;
    assign ID_ERR_CNT = 8'h00;
`endif

    for (genvar gi = 0; gi < EVENT_WORDS; gi++) begin : g_word
        assign word_fmt[gi] = {HEADER, flags_reg, 4'(gi), buffer_reg[gi]};
    end

    assign FIFO_READ      = fifo_read_reg;
    assign OUT_FIFO_EMPTY = (state_reg != DRAIN);
    assign OUT_FIFO_DATA  = (state_reg == DRAIN) ? word_fmt[out_idx_reg] : 32'h0;
    assign EVENT_CNT      = event_cnt_reg;
    assign BUSY           = (state_reg != IDLE);

endmodule

// File: tb/tb_tlu_event_framer.sv
// Self-checking bench for tlu_event_framer: table vectors, corner sequences and
// randomized events against a queue-based event model.
module tb_tlu_event_framer;

`ifdef TLU_FRAMER_ID_CHECK_EN
    localparam bit ID_CHECK = 1'b1;
`else
    localparam bit ID_CHECK = 1'b0;
`endif

    typedef struct {
        logic [31:0] id;
        bit          err;
        int          err_cnt;
    } vec_t;

    logic        bus_clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data = 16'h0;
    logic        out_fifo_read = 1'b0;
    logic        fifo_read;
    logic        out_fifo_empty;
    logic [31:0] out_fifo_data;
    logic [31:0] event_cnt;
    logic [7:0]  id_err_cnt;
    logic        busy;

    always #5 bus_clk = ~bus_clk;

    tlu_event_framer #(.HEADER(8'hC0)) dut (
        .BUS_CLK       (bus_clk),
        .BUS_RST       (bus_rst),
        .ENABLE        (enable),
        .FIFO_READ     (fifo_read),
        .FIFO_EMPTY    (fifo_empty),
        .FIFO_DATA     (fifo_data),
        .OUT_FIFO_READ (out_fifo_read),
        .OUT_FIFO_EMPTY(out_fifo_empty),
        .OUT_FIFO_DATA (out_fifo_data),
        .EVENT_CNT     (event_cnt),
        .ID_ERR_CNT    (id_err_cnt),
        .BUSY          (busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          drained = 0;
    logic [15:0] up_q[$];
    logic [31:0] exp_q[$];

    // Event model state
    bit          m_first = 1'b1;
    logic [31:0] m_last = 32'd0;
    int          m_err = 0;
    int          m_evt = 0;

    int          rd_mode = 0;   // 0: always read, 1: toggle, 2: random
    logic [3:0]  last_flags = 4'd0;
    bit          b2b_check = 1'b0;
    bit          b2b_pending = 1'b0;
    int          pop9_cycle = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic refresh();
        fifo_empty = (up_q.size() == 0);
        fifo_data  = fifo_empty ? 16'h0 : up_q[0];
    endtask

    task automatic tick();
        logic        rd_up, rd_out, emp_out, rst_s;
        logic [31:0] dout, w;
        logic [15:0] dummy;
        rd_up   = fifo_read;
        rd_out  = out_fifo_read;
        emp_out = out_fifo_empty;
        dout    = out_fifo_data;
        rst_s   = bus_rst;
        @(posedge bus_clk);
        #1;
        cycle++;
        if (!rst_s && rd_up === 1'b1) begin
            if (up_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL up_underflow: pop with empty upstream at cycle %0d, required no pop", cycle);
            end else begin
                dummy = up_q.pop_front();
            end
        end
        if (!rst_s && emp_out === 1'b0) begin
            chk("read_in_drain", 32'(rd_up), 32'd0);
        end
        if (!rst_s && rd_out === 1'b1 && emp_out === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_word: got %h required no word", dout);
            end else begin
                w = exp_q.pop_front();
                chk("out_word", dout, w);
                if (dout[19:16] == 4'd0) last_flags = dout[23:20];
                if (dout[19:16] == 4'd9) begin
                    drained++;
                    $display("event %0d drained at cycle %0d, last word %h", drained, cycle, dout);
                    if (b2b_check && up_q.size() > 0) begin
                        b2b_pending = 1'b1;
                        pop9_cycle  = cycle;
                    end
                end
            end
        end
        if (b2b_pending && fifo_read === 1'b1) begin
            chk("b2b_gap", 32'(cycle - pop9_cycle), 32'd1);
            b2b_pending = 1'b0;
        end
        refresh();
        if (bus_rst) out_fifo_read = 1'b0;
        else if (rd_mode == 0) out_fifo_read = 1'b1;
        else if (rd_mode == 1) out_fifo_read = ~out_fifo_read;
        else out_fifo_read = 1'($urandom_range(0, 1));
    endtask

    task automatic push_event(input logic [63:0] le, input logic [63:0] ts, input logic [31:0] id);
        logic [15:0] words[10];
        bit          err;
        logic [3:0]  flags;
        for (int i = 0; i < 4; i++) begin
            words[i]     = le[16*i +: 16];
            words[4 + i] = ts[16*i +: 16];
        end
        words[8] = id[15:0];
        words[9] = id[31:16];
        err   = ID_CHECK && !m_first && (id != m_last + 32'd1);
        flags = {2'b00, m_first, err};
        for (int i = 0; i < 10; i++) begin
            up_q.push_back(words[i]);
            exp_q.push_back({8'hC0, flags, 4'(i), words[i]});
        end
        if (err && m_err < 255) m_err++;
        m_last  = id;
        m_first = 1'b0;
        m_evt++;
        refresh();
    endtask

    task automatic do_reset();
        bus_rst = 1'b1;
        tick();
        bus_rst = 1'b0;
        up_q.delete();
        exp_q.delete();
        m_first = 1'b1;
        m_last  = 32'd0;
        m_err   = 0;
        m_evt   = 0;
        b2b_pending = 1'b0;
        refresh();
    endtask

    task automatic run_drain(input int remain, input bit chk_cnt);
        int n = 0;
        while ((exp_q.size() > remain || busy !== 1'b0) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required %0d", exp_q.size(), remain);
        end
        if (chk_cnt) begin
            chk("event_cnt", event_cnt, 32'(m_evt));
            chk("id_err_cnt", 32'(id_err_cnt), 32'(m_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int   n;
        tbl[0] = '{32'd5,         1'b1, 1};
        tbl[1] = '{32'd6,         1'b0, 1};
        tbl[2] = '{32'd7,         1'b0, 1};
        tbl[3] = '{32'hFFFF_FFFF, 1'b1, 2};
        tbl[4] = '{32'd0,         1'b0, 2};
        tbl[5] = '{32'd10,        1'b1, 3};
        tbl[6] = '{32'd13,        1'b1, 4};
        tbl[7] = '{32'd14,        1'b0, 4};

        // Reset values
        do_reset();
        tick();
        chk("rst_fifo_read", 32'(fifo_read), 32'd0);
        chk("rst_out_empty", 32'(out_fifo_empty), 32'd1);
        chk("rst_out_data", out_fifo_data, 32'd0);
        chk("rst_event_cnt", event_cnt, 32'd0);
        chk("rst_id_err", 32'(id_err_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Single event with latency
        enable = 1'b1;
        push_event(64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("fill_read", 32'(fifo_read), 32'd1);
        end
        tick();
        chk("lat_read_low", 32'(fifo_read), 32'd0);
        chk("lat_out_empty", 32'(out_fifo_empty), 32'd0);
        chk("lat_first_word", out_fifo_data, 32'hC020_0001);
        run_drain(0, 1'b1);
        chk("single_evt_cnt", event_cnt, 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // Table-driven ID sequence
        for (int i = 0; i < 8; i++) begin
            push_event({$urandom, $urandom}, {$urandom, $urandom}, tbl[i].id);
            run_drain(0, 1'b0);
            chk("tbl_flags", 32'(last_flags), 32'({3'b000, tbl[i].err & ID_CHECK}));
            chk("tbl_err_cnt", 32'(id_err_cnt), ID_CHECK ? 32'(tbl[i].err_cnt) : 32'd0);
            chk("tbl_evt_cnt", event_cnt, 32'(i + 2));
        end

        // Output backpressure, two queued events
        rd_mode   = 1;
        b2b_check = 1'b1;
        push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
        push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
        run_drain(0, 1'b1);
        b2b_check = 1'b0;
        rd_mode   = 0;

        // Error-counter saturation
        do_reset();
        for (int k = 0; k < 300; k++) begin
            push_event({$urandom, $urandom}, {$urandom, $urandom}, 32'(k * 2));
            run_drain(0, 1'b0);
        end
        chk("sat_err_cnt", 32'(id_err_cnt), ID_CHECK ? 32'd255 : 32'd0);
        chk("sat_evt_cnt", event_cnt, 32'd300);

        // Reset at fill index 5
        push_event({$urandom, $urandom}, {$urandom, $urandom}, 32'h1234);
        for (int k = 0; k < 6; k++) tick();
        chk("abort_in_fill", 32'(fifo_read), 32'd1);
        do_reset();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_read", 32'(fifo_read), 32'd0);
        chk("abort_out_empty", 32'(out_fifo_empty), 32'd1);
        chk("abort_evt_cnt", event_cnt, 32'd0);
        push_event({$urandom, $urandom}, {$urandom, $urandom}, 32'h55);
        run_drain(0, 1'b1);
        chk("fresh_first_flag", 32'(last_flags), 32'd2);
        chk("fresh_evt_cnt", event_cnt, 32'd1);

        // ENABLE low with upstream non-empty
        enable = 1'b0;
        push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("en_off_read", 32'(fifo_read), 32'd0);
        end
        enable = 1'b1;
        run_drain(0, 1'b1);

        // ENABLE dropped at drain index 3
        push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
        push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
        n = 0;
        while (!(out_fifo_empty === 1'b0 && out_fifo_data[19:16] == 4'd3) && n < 100) begin
            tick();
            n++;
        end
        chk("en_drop_reached", 32'(n < 100), 32'd1);
        enable = 1'b0;
        run_drain(10, 1'b0);
        chk("en_drop_remaining", 32'(exp_q.size()), 32'd10);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("en_drop_idle", 32'({busy, fifo_read}), 32'd0);
        end
        enable = 1'b1;
        run_drain(0, 1'b1);

        // Randomized events and consumer
        rd_mode = 2;
        for (int k = 0; k < 25; k++) begin
            push_event({$urandom, $urandom}, {$urandom, $urandom},
                       ($urandom_range(0, 3) == 0) ? 32'($urandom) : m_last + 32'd1);
            if ($urandom_range(0, 1) == 1)
                push_event({$urandom, $urandom}, {$urandom, $urandom}, m_last + 32'd1);
            run_drain(0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
